// File: rtl/hwpe_stream_split_decoupled_pkg.sv
// Shared HWPE-Stream helpers: pointer-width function and per-lane status struct.
// Used by hwpe_stream_split_decoupled and hwpe_stream_split_lane_fifo.
package hwpe_stream_package;

    // A depth-1 FIFO logically needs no pointer bits; a 1-bit pointer held at 0 stands in.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef struct packed {
        logic empty;
        logic full;
    } lane_status_t;

endpackage

// File: rtl/hwpe_stream_split_lane_fifo.sv
// Single-lane FIFO with a registered head entry, clear and empty/full flags.
module hwpe_stream_split_lane_fifo
    import hwpe_stream_package::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned STRB_WIDTH = 8,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [STRB_WIDTH-1:0] wr_strb,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [STRB_WIDTH-1:0] rd_strb,
    output lane_status_t          status
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [STRB_WIDTH-1:0] strb;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head_q, head_d;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign status.empty = (count_q == '0);
    assign status.full  = (count_q == CNT_W'(DEPTH));
    assign do_push      = wr_en & ~status.full;
    assign do_pop       = rd_en & ~status.empty & ~clear_i;

    // Next head: the entry the read pointer lands on, bypassed from the write port
    // when that entry is being written on this same edge.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        head_d   = mem[rd_ptr_d];
        if (do_push && (wr_ptr_q == rd_ptr_d)) begin
            head_d = {wr_strb, wr_data};
        end
    end

    // NOTE: storage array carries no reset; validity lives in count_q and the reset head.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_q] <= {wr_strb, wr_data};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            rd_ptr_q <= rd_ptr_d;
            head_q   <= head_d;
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    assign rd_data = head_q.data;
    assign rd_strb = head_q.strb;

endmodule

// File: rtl/hwpe_stream_split_decoupled.sv
// Splits one wide stream into NB_OUT_STREAMS lanes, each buffered by its own FIFO.
// Optional HWPE_STREAM_SPLIT_DECOUPLED_SKIP_EN: lanes with an all-zero strobe are not written.
module hwpe_stream_split_decoupled
    import hwpe_stream_package::*;
#(
    parameter int unsigned NB_OUT_STREAMS = 2,
    parameter int unsigned DATA_WIDTH_IN  = 128,
    parameter int unsigned LANE_DEPTH     = 2,
    localparam int unsigned DATA_WIDTH_OUT = DATA_WIDTH_IN / NB_OUT_STREAMS,
    localparam int unsigned STRB_WIDTH_OUT = DATA_WIDTH_OUT / 8
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic                                          clear_i,
    input  logic [DATA_WIDTH_IN-1:0]                      push_data_i,
    input  logic [DATA_WIDTH_IN/8-1:0]                    push_strb_i,
    input  logic                                          push_valid_i,
    output logic                                          push_ready_o,
    output logic [NB_OUT_STREAMS-1:0][DATA_WIDTH_OUT-1:0] pop_data_o,
    output logic [NB_OUT_STREAMS-1:0][STRB_WIDTH_OUT-1:0] pop_strb_o,
    output logic [NB_OUT_STREAMS-1:0]                     pop_valid_o,
    input  logic [NB_OUT_STREAMS-1:0]                     pop_ready_i,
    output logic [NB_OUT_STREAMS-1:0]                     empty_o,
    output logic [NB_OUT_STREAMS-1:0]                     full_o
);

    lane_status_t                status [NB_OUT_STREAMS];
    logic [NB_OUT_STREAMS-1:0]   lane_wr;
    logic                        accept;

    // Ready never looks at the consumers, only at registered fullness.
    assign push_ready_o = ~clear_i & ~|full_o;
    assign accept       = push_valid_i & push_ready_o;

    for (genvar ii = 0; ii < NB_OUT_STREAMS; ii++) begin : gen_lane
`ifdef HWPE_STREAM_SPLIT_DECOUPLED_SKIP_EN
        assign lane_wr[ii] = accept & (|push_strb_i[ii*STRB_WIDTH_OUT +: STRB_WIDTH_OUT]);
`else
        assign lane_wr[ii] = accept;
`endif

        hwpe_stream_split_lane_fifo #(
            .DATA_WIDTH (DATA_WIDTH_OUT),
            .STRB_WIDTH (STRB_WIDTH_OUT),
            .DEPTH      (LANE_DEPTH)
        ) i_lane_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .clear_i (clear_i),
            .wr_en   (lane_wr[ii]),
            .wr_data (push_data_i[ii*DATA_WIDTH_OUT +: DATA_WIDTH_OUT]),
            .wr_strb (push_strb_i[ii*STRB_WIDTH_OUT +: STRB_WIDTH_OUT]),
            .rd_en   (pop_ready_i[ii]),
            .rd_data (pop_data_o[ii]),
            .rd_strb (pop_strb_o[ii]),
            .status  (status[ii])
        );

        assign empty_o[ii]     = status[ii].empty;
        assign full_o[ii]      = status[ii].full;
        assign pop_valid_o[ii] = ~status[ii].empty;
    end

endmodule

// File: tb/tb_hwpe_stream_split_decoupled.sv
// Randomized self-checking bench: per-lane queue model of the split, plus directed
// reset, slow-lane, strobe-skip, clear and depth-1 throughput scenarios.
module tb_hwpe_stream_split_decoupled;

    localparam int NB    = 2;
    localparam int DW    = 128;
    localparam int DWO   = DW / NB;
    localparam int SWO   = DWO / 8;
    localparam int DEPTH = 2;

    logic                    clk = 1'b0;
    logic                    rst_i, clear_i;
    logic [DW-1:0]           push_data;
    logic [DW/8-1:0]         push_strb;
    logic                    push_valid, push_ready;
    logic [NB-1:0][DWO-1:0]  pop_data;
    logic [NB-1:0][SWO-1:0]  pop_strb;
    logic [NB-1:0]           pop_valid, pop_ready, empty, full;

    logic                    d1_valid, d1_ready;
    logic [NB-1:0][DWO-1:0]  d1_data;
    logic [NB-1:0][SWO-1:0]  d1_strb;
    logic [NB-1:0]           d1_pvalid, d1_empty, d1_full;
    logic [NB-1:0]           d1_pop_ready;

    int errors = 0;
    int checks = 0;
    logic last_acc;

    // Model: one queue of {strb,data} per lane.
    logic [SWO+DWO-1:0] q [NB][$];

    always #5 clk = ~clk;

    hwpe_stream_split_decoupled #(
        .NB_OUT_STREAMS (NB), .DATA_WIDTH_IN (DW), .LANE_DEPTH (DEPTH)
    ) dut (
        .clk_i (clk), .rst_i (rst_i), .clear_i (clear_i),
        .push_data_i (push_data), .push_strb_i (push_strb),
        .push_valid_i (push_valid), .push_ready_o (push_ready),
        .pop_data_o (pop_data), .pop_strb_o (pop_strb),
        .pop_valid_o (pop_valid), .pop_ready_i (pop_ready),
        .empty_o (empty), .full_o (full)
    );

    hwpe_stream_split_decoupled #(
        .NB_OUT_STREAMS (NB), .DATA_WIDTH_IN (DW), .LANE_DEPTH (1)
    ) dut_d1 (
        .clk_i (clk), .rst_i (rst_i), .clear_i (clear_i),
        .push_data_i (push_data), .push_strb_i (push_strb),
        .push_valid_i (d1_valid), .push_ready_o (d1_ready),
        .pop_data_o (d1_data), .pop_strb_o (d1_strb),
        .pop_valid_o (d1_pvalid), .pop_ready_i (d1_pop_ready),
        .empty_o (d1_empty), .full_o (d1_full)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic lane_written(input int l);
`ifdef HWPE_STREAM_SPLIT_DECOUPLED_SKIP_EN
        return |push_strb[l*SWO +: SWO];
`else
        return 1'b1;
`endif
    endfunction

    // Compare outputs against the model mid-cycle, then advance the model across the next edge.
    task automatic step();
        logic exp_ready;
        @(negedge clk);
        exp_ready = !clear_i;
        for (int l = 0; l < NB; l++) if (q[l].size() >= DEPTH) exp_ready = 1'b0;
        check("push_ready", push_ready, exp_ready);
        for (int l = 0; l < NB; l++) begin
            check($sformatf("valid[%0d]", l), pop_valid[l], q[l].size() != 0);
            check($sformatf("empty[%0d]", l), empty[l], q[l].size() == 0);
            check($sformatf("full[%0d]", l), full[l], q[l].size() == DEPTH);
            if (q[l].size() != 0)
                check($sformatf("head[%0d]", l), {pop_strb[l], pop_data[l]}, q[l][0]);
        end
        last_acc = push_valid & exp_ready;
        if (clear_i) begin
            for (int l = 0; l < NB; l++) q[l].delete();
        end else begin
            for (int l = 0; l < NB; l++) begin
                if (pop_ready[l] && q[l].size() != 0) void'(q[l].pop_front());
                if (last_acc && lane_written(l))
                    q[l].push_back({push_strb[l*SWO +: SWO], push_data[l*DWO +: DWO]});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        push_valid = 1'b0;
        pop_ready  = '1;
        for (int i = 0; i < 4; i++) step();
    endtask

    initial begin
        int accepted;
        int budget;
        rst_i = 1'b1; clear_i = 1'b0;
        push_data = '0; push_strb = '1; push_valid = 1'b0; pop_ready = '0;
        d1_valid = 1'b0; d1_pop_ready = '1;
        #12 rst_i = 1'b0;
        #1;

        // Reset state
        check("rst_data", pop_data, '0);
        check("rst_strb", pop_strb, '0);
        check("rst_empty", empty, 2'b11);
        check("rst_full", full, 2'b00);
        check("rst_ready", push_ready, 1'b1);
        @(posedge clk); #1;
        step();

        // Straight-through at one beat per cycle
        pop_ready = '1;
        push_valid = 1'b1;
        push_data = 128'hDDDD_CCCC_BBBB_AAAA_4444_3333_2222_1111;
        step();
        check("st_lane0", pop_data[0], 64'h4444_3333_2222_1111);
        check("st_lane1", pop_data[1], 64'hDDDD_CCCC_BBBB_AAAA);
        for (int i = 0; i < 4; i++) begin
            push_data = {$urandom, $urandom, $urandom, $urandom};
            step();
            check("st_rate", last_acc, 1'b1);
        end
        drain();

        // Slow lane 1: two beats fill it, third waits until release
        pop_ready = 2'b01;
        push_valid = 1'b1;
        accepted = 0;
        for (int i = 0; i < 2; i++) begin
            push_data = {$urandom, $urandom, $urandom, $urandom};
            step();
            accepted += int'(last_acc);
        end
        check("slow_accepted", accepted, 2);
        check("slow_full1", full[1], 1'b1);
        check("slow_ready", push_ready, 1'b0);
        push_data = {$urandom, $urandom, $urandom, $urandom};
        step();
        check("slow_blocked", last_acc, 1'b0);
        pop_ready = 2'b11;
        budget = 0;
        do begin
            step();
            budget++;
        end while (!last_acc && budget < 10);
        check("slow_third_accepted", last_acc, 1'b1);
        drain();

        // Zero strobe on lane 1
        push_valid = 1'b1;
        pop_ready = 2'b00;
        push_data = {$urandom, $urandom, $urandom, $urandom};
        push_strb = 16'h00FF;
        step();
        push_valid = 1'b0;
        push_strb = '1;
`ifdef HWPE_STREAM_SPLIT_DECOUPLED_SKIP_EN
        check("skip_lane1_empty", pop_valid[1], 1'b0);
`else
        check("noskip_lane1_valid", pop_valid[1], 1'b1);
        check("noskip_lane1_strb", pop_strb[1], 8'h00);
`endif
        check("skip_lane0_valid", pop_valid[0], 1'b1);
        drain();

        // Clear together with valid
        pop_ready = 2'b00;
        push_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            push_data = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        check("clr_full0", full[0], 1'b1);
        clear_i = 1'b1;
        step();
        check("clr_no_accept", last_acc, 1'b0);
        clear_i = 1'b0;
        push_valid = 1'b0;
        check("clr_empty", empty, 2'b11);
        step();

        // Depth-1 instance peaks at one beat every two cycles
        d1_valid = 1'b1;
        accepted = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            accepted += int'(d1_ready);
        end
        check("d1_rate", accepted, 10);
        d1_valid = 1'b0;
        @(posedge clk); #1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            push_valid = ($urandom_range(0, 3) != 0);
            push_data  = {$urandom, $urandom, $urandom, $urandom};
            push_strb  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) push_strb[SWO-1:0] = '0;
            if ($urandom_range(0, 3) == 0) push_strb[DW/8-1:SWO] = '0;
            pop_ready  = {1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0 ? 0 : 1)};
            clear_i    = ($urandom_range(0, 39) == 0);
            step();
        end
        clear_i = 1'b0;
        drain();

        // Asynchronous reset mid-stream
        pop_ready = 2'b00;
        push_valid = 1'b1;
        push_strb = '1;
        for (int i = 0; i < 2; i++) begin
            push_data = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        push_valid = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        check("arst_valid", pop_valid, 2'b00);
        check("arst_empty", empty, 2'b11);
        for (int l = 0; l < NB; l++) q[l].delete();
        @(negedge clk);
        rst_i = 1'b0;
        @(posedge clk); #1;
        step();
        check("arst_ready", push_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hwpe_stream_split_decoupled.md
# hwpe_stream_split_decoupled

Splits one wide HWPE-Stream input into `NB_OUT_STREAMS` narrower output streams. Each output lane has its own small FIFO, so lanes drain independently. One slow consumer no longer stalls the others beat-by-beat. The block sits between an HWPE datapath and its TCDM store ports, where per-port grant latencies differ.

## Interface
- `NB_OUT_STREAMS`, 2: number of output lanes; ≥1.
- `DATA_WIDTH_IN`, 128: input data width; must be a multiple of `8*NB_OUT_STREAMS`.
- `LANE_DEPTH`, 2: entries per lane FIFO; power of two, ≥1.
- Derived: `DATA_WIDTH_OUT = DATA_WIDTH_IN/NB_OUT_STREAMS`, `STRB_WIDTH_OUT = DATA_WIDTH_OUT/8`.
- `clk_i`  in  1: clock; everything is rising-edge.
- `rst_i`  in  1: asynchronous, active-high reset.
- `clear_i`  in  1: synchronous flush of all lanes.
- `push_i`  sink  `DATA_WIDTH_IN`: wide input stream (`data`, `strb`, `valid`, `ready`).
- `pop_o[NB_OUT_STREAMS-1:0]`  source  `DATA_WIDTH_OUT`: lane output streams.
- `empty_o`  out  `NB_OUT_STREAMS`: per-lane FIFO empty flag.
- `full_o`  out  `NB_OUT_STREAMS`: per-lane FIFO full flag.

## Operation
- Lane `ii` carries data bits `[(ii+1)*DATA_WIDTH_OUT-1 : ii*DATA_WIDTH_OUT]` and the matching strobe slice of `push_i`.
- Input handshake:
  - `push_i.ready = ~clear_i & ~|full_o`. It depends only on registered state and `clear_i`, never on any `pop_o[*].ready`.
  - An input beat is accepted when `push_i.valid & push_i.ready`. Each participating lane then writes its slice into its FIFO tail in the same edge.
- Output handshake, per lane:
  - `pop_o[ii].valid = ~empty_o[ii]`.
  - `data` and `strb` come from the FIFO head and are registered.
  - The head is popped on `valid & ready`.
  - Lanes pop independently of one another and of the input.
- Each lane FIFO counts occupancy from 0 to `LANE_DEPTH`, with wrap-around read and write pointers of `$clog2(LANE_DEPTH)` bits (0 bits when `LANE_DEPTH=1`).
- Simultaneous push and pop on the same lane:
  - Allowed when not full; occupancy stays unchanged.
  - When full, no push occurs because `push_i.ready` is already 0. There is no full-bypass.
- A lane that is empty and receives a push shows valid on the next cycle. There is no fall-through.
- `clear_i`:
  - Resets pointers and counts to 0 on the next edge.
  - Any pop on that cycle is ignored.
  - No beat is accepted on a clear cycle because ready is 0.
- Output ordering:
  - Within a lane, order is preserved.
  - Across lanes, there is no ordering relation beyond each lane's FIFO order.

## Timing
- Reset state:
  - All counts and pointers are 0, so `empty_o` is all-ones and `full_o` is 0.
  - `pop_o[*].valid` is 0 and `pop_o[*].data` and `strb` are 0.
  - `push_i.ready` is 1 (when `clear_i` is 0).
- Latency: an input accepted at edge N is visible as `pop_o` valid in the cycle after edge N, i.e. 1 cycle.
- Throughput: 1 beat/cycle when `LANE_DEPTH ≥ 2` and all lanes pop every cycle. With `LANE_DEPTH=1`, the peak is 1 beat every 2 cycles.
- `rst_i` asserted mid-transfer discards all stored data immediately and asynchronously.
- `pop_o[ii].valid` must not drop without a handshake, except through `clear_i` or `rst_i`.

## Configuration
- `HWPE_STREAM_SPLIT_DECOUPLED_SKIP_EN`
  - Defined: on acceptance, a lane whose strobe slice is all zero is not written. That lane's FIFO and output see nothing for that beat.
  - Not defined: every lane is written on every accepted beat, regardless of strobe, including an all-zero strobe.
- `push_i.ready` is identical in both builds: it requires all lanes not full.

## Structure
- Shared package `hwpe_stream_package` holds:
  - the `clog2`-based pointer-width helper constant function;
  - a `lane_status_t` packed struct (`empty`, `full`).
- Sub-module `hwpe_stream_split_lane_fifo`: a single-lane FIFO with `wr_en`, `rd_en`, `clear_i`, registered head, and `empty`/`full` flags. It is instantiated once per lane in a generate loop.
- The top level contains only the slicing, the optional strobe-skip logic, and the ready reduction.

## Test plan
- **Reset:** assert `rst_i` mid-stream with 2 lanes holding data → outputs go invalid immediately, `empty_o=2'b11`, and `push_i.ready=1` after release.
- **Straight-through:** defaults, push `0xDDDD_CCCC_BBBB_AAAA_…` with `strb` all-ones, both lanes always ready → lane 0 outputs the low 64 bits and lane 1 the high 64 bits, 1 cycle later, at 1 beat/cycle.
- **Slow lane:** lane 1 ready held low, push 3 beats → lane 0 delivers 2 beats, `full_o[1]` rises after 2 beats, and `push_i.ready` goes 0. Releasing lane 1 drains both remaining beats in order, then the 3rd beat is accepted.
- **Skip:** with the macro defined, push with lane-1 `strb=0` → lane 1 stays empty and lane 0 outputs the beat. Without the macro, lane 1 outputs data with `strb=0`.
- **Clear:** fill lane 0 to full, assert `clear_i` together with `push_i.valid` → no beat accepted, and all lanes are empty on the next cycle.
- **Depth 1:** `LANE_DEPTH=1`, consumers always ready, continuous valid → exactly 1 beat accepted every 2 cycles.
